vc_fifo_bank: RTL and testbench
===============================

# vc_fifo_bank

Parametrised bank of NUM_VC independent virtual-channel FIFOs sharing one write port, for the PCIe transmit-layer datapath. Each VC has its own storage, pointers, occupancy count, per-VC almost-full/almost-empty thresholds, sticky error and a show-ahead head word for the downstream arbiter. It supersedes the single-channel VC FIFOs: it adds arbitrary VC count, read-during-write when full, threshold-range flags and sticky error reporting.

## Interface

- DATA_WIDTH, 6, word width
- ADDR_WIDTH, 2, log2 of per-VC depth; DEPTH = 2**ADDR_WIDTH
- NUM_VC, 2, number of virtual channels (>=1); VC_SEL_W = max(1, clog2(NUM_VC))
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- init  in  1  synchronous enable; low = synchronous clear (same effect as reset), high = run
- wr_enable  in  1  write request
- wr_vc  in  VC_SEL_W  target VC of the write; values >= NUM_VC are illegal
- data_in  in  DATA_WIDTH  write data
- rd_enable  in  NUM_VC  per-VC read request; any combination allowed
- umbral_af  in  NUM_VC*ADDR_WIDTH  per-VC almost-full margin, VC i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- umbral_ae  in  NUM_VC*ADDR_WIDTH  per-VC almost-empty threshold, same packing
- data_out  out  NUM_VC*DATA_WIDTH  registered read data, per VC
- valid_out  out  NUM_VC  data_out slice valid, per VC
- data_head  out  NUM_VC*DATA_WIDTH  combinational head word; 0 when that VC is empty
- count  out  NUM_VC*(ADDR_WIDTH+1)  occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty, error  out  NUM_VC each  per-VC status

## Operation

- Reset or init low: wr_ptr, rd_ptr and count go to 0; data_out goes to 0; valid_out and error go to 0. Storage is not cleared. Flags follow count, so empty=1, almost_empty=1, full=0, almost_full=0 (for umbral_af < DEPTH).
- Write: when wr_enable is high, VC v = wr_vc is accepted if count[v] < DEPTH, or if count[v] == DEPTH and rd_enable[v] is high in the same cycle. Acceptance stores mem_v[wr_ptr_v] = data_in and increments wr_ptr_v.
- Rejected write (full and no same-cycle read): data is dropped, pointers are unchanged and error[v] is set.
- Read on VC i: when rd_enable[i] is high and count[i] > 0, data_out_i <= mem_i[rd_ptr_i], valid_out[i] <= 1 and rd_ptr_i increments. Otherwise data_out_i <= 0 and valid_out[i] <= 0.
- Read while empty: error[i] is set. A same-cycle write to an empty VC is not bypassed; the read still fails.
- Count update: +1 on an accepted write only, -1 on a valid read only, unchanged on both or neither.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
- error is sticky; it clears only on reset or init low.
- Flags (combinational from count):
  - full = count == DEPTH
  - empty = count == 0
  - almost_full = count >= DEPTH - umbral_af
  - almost_empty = count <= umbral_ae
  - count and the DEPTH comparison are ADDR_WIDTH+1 bits wide.
- wr_vc >= NUM_VC: the write is ignored and no error is raised. The testbench asserts this never occurs.

## Timing

- Write-to-visible latency: an accepted write at edge N updates count, flags and data_head by edge N (visible after the edge); it is readable from cycle N+1.
- Read latency is 1 cycle: rd_enable sampled at edge N gives data_out/valid_out valid after edge N for one cycle.
- data_head reflects mem[rd_ptr] combinationally; it advances in the same cycle rd_ptr does.
- Async reset acts immediately mid-transfer. Any in-flight read result is lost and valid_out drops without waiting for a clock.
- Back-to-back reads on one VC every cycle give one word per cycle until empty.

## Structure

- Package vc_fifo_pkg holds VC_SEL_W computation function, slice helper localparams and a constant for the packing order (VC 0 in LSBs).
- Sub-module vc_fifo_channel: one FIFO with storage, pointers, count, flags, sticky error and read register.
  - vc_fifo_bank generates NUM_VC instances and decodes wr_vc into per-channel write enables.

## Test plan

- Reset/flags: assert reset mid-sequence -> all count=0, empty=11, valid_out=00, error=00 immediately.
- Fill and overflow (DEPTH=4, VC0): write 0x01..0x05 with no reads -> count0 = 1,2,3,4,4; full0=1 after the 4th write; the 5th write sets error0=1; VC1 unaffected.
- Full with simultaneous read/write: VC0 full holding 0x01..0x04; write 0x05 plus rd_enable=01 -> data_out0=0x01, count0 stays 4, error0=0; draining yields 0x02,0x03,0x04,0x05.
- Underflow and wrap: VC1 empty, rd_enable=10 -> valid_out=00, error1=1. Then run 6 write/read pairs -> data returned in order across the pointer wrap.
- Thresholds: umbral_af=1, umbral_ae=1 on VC0. Counts 0,1,2,3,4 -> almost_empty = 1,1,0,0,0; almost_full = 0,0,0,1,1.
- Parallel channels: write alternately to VC0/VC1, then rd_enable=11 -> both valid_out bits set in one cycle with the correct per-VC data; init low for one cycle clears the sticky errors.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// Shared helpers for the virtual-channel FIFO bank: select-width sizing and
// the packing order of per-VC slices on the flat buses.
package vc_fifo_pkg;

  // VC 0 occupies the least-significant slice of every packed per-VC bus.
  localparam int VC_PACK_BASE = 0;

  function automatic int vc_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lsb(input int vc, input int w);
    return VC_PACK_BASE + vc * w;
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Write port, per-VC read requests and per-VC status/data of the FIFO bank.
interface vc_fifo_bank_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_VC     = 2
);
  import vc_fifo_pkg::*;
  localparam int VC_SEL_W = vc_sel_w(NUM_VC);

  logic                           wr_enable;
  logic [VC_SEL_W-1:0]            wr_vc;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [NUM_VC-1:0]              rd_enable;
  logic [NUM_VC*DATA_WIDTH-1:0]   data_out;
  logic [NUM_VC-1:0]              valid_out;
  logic [NUM_VC*DATA_WIDTH-1:0]   data_head;
  logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count;
  logic [NUM_VC-1:0]              full;
  logic [NUM_VC-1:0]              empty;
  logic [NUM_VC-1:0]              almost_full;
  logic [NUM_VC-1:0]              almost_empty;
  logic [NUM_VC-1:0]              error;

  modport master (
    output wr_enable, wr_vc, data_in, rd_enable,
    input  data_out, valid_out, data_head, count,
           full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  wr_enable, wr_vc, data_in, rd_enable,
    output data_out, valid_out, data_head, count,
           full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/vc_fifo_channel.sv
// One virtual-channel FIFO: storage, pointers, occupancy, threshold flags,
// sticky error and a registered read port plus a show-ahead head word.
module vc_fifo_channel #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_af,
  input  logic [ADDR_WIDTH-1:0] i_ae,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_vld_p1;
  logic                  r_error;

  logic w_full, w_empty, w_rd_ok, w_wr_ok, w_err;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = i_rd_en && !w_empty;
  // A full channel still takes a write when the same cycle frees a slot.
  assign w_wr_ok = i_wr_en && (!w_full || i_rd_en);
  assign w_err   = (i_wr_en && w_full && !i_rd_en) || (i_rd_en && w_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || !init) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      // Stage p1: registered read result.
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
        r_data_p1 <= r_mem[r_rd_ptr];
        r_vld_p1  <= 1'b1;
      end else begin
        r_data_p1 <= '0;
        r_vld_p1  <= 1'b0;
      end
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + (ADDR_WIDTH+1)'(1);
      else if (!w_wr_ok && w_rd_ok) r_count <= r_count - (ADDR_WIDTH+1)'(1);
      if (w_err) r_error <= 1'b1;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (init && w_wr_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data         = r_data_p1;
  assign o_valid        = r_vld_p1;
  assign o_head         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= (DEPTH_C - {1'b0, i_af}));
  assign o_almost_empty = (r_count <= {1'b0, i_ae});
  assign o_error        = r_error;
endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs behind one shared write port; wr_vc is
// decoded into per-channel write enables, out-of-range selects are dropped.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_VC     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_af,
  input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_ae,
  vc_fifo_bank_if.slave                bus
);
  localparam int VC_SEL_W = vc_sel_w(NUM_VC);

  logic [NUM_VC-1:0] w_wr_en;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    localparam int DLSB = slice_lsb(i, DATA_WIDTH);
    localparam int ALSB = slice_lsb(i, ADDR_WIDTH);
    localparam int CLSB = slice_lsb(i, ADDR_WIDTH + 1);

    assign w_wr_en[i] = bus.wr_enable && (bus.wr_vc == VC_SEL_W'(i));

    vc_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .i_wr_en        (w_wr_en[i]),
      .i_rd_en        (bus.rd_enable[i]),
      .i_data         (bus.data_in),
      .i_af           (umbral_af[ALSB +: ADDR_WIDTH]),
      .i_ae           (umbral_ae[ALSB +: ADDR_WIDTH]),
      .o_data         (bus.data_out[DLSB +: DATA_WIDTH]),
      .o_valid        (bus.valid_out[i]),
      .o_head         (bus.data_head[DLSB +: DATA_WIDTH]),
      .o_count        (bus.count[CLSB +: ADDR_WIDTH+1]),
      .o_full         (bus.full[i]),
      .o_empty        (bus.empty[i]),
      .o_almost_full  (bus.almost_full[i]),
      .o_almost_empty (bus.almost_empty[i]),
      .o_error        (bus.error[i])
    );
  end
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank (DATA_WIDTH=6, DEPTH=4, NUM_VC=2).
module tb_vc_fifo_bank;
  localparam int DW = 6;
  localparam int AW = 2;
  localparam int NV = 2;

  logic clk = 1'b0;
  logic reset;
  logic init;
  logic [NV*AW-1:0] umbral_af;
  logic [NV*AW-1:0] umbral_ae;

  int n_chk = 0;
  int n_err = 0;

  vc_fifo_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) bus ();

  vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .umbral_af (umbral_af),
    .umbral_ae (umbral_ae),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && bus.wr_enable)
      assert (int'(bus.wr_vc) < NV) else $error("wr_vc out of range: %0d", bus.wr_vc);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cnt(input int v);
    return int'(bus.count[v*(AW+1) +: AW+1]);
  endfunction

  function automatic int dout(input int v);
    return int'(bus.data_out[v*DW +: DW]);
  endfunction

  function automatic int head(input int v);
    return int'(bus.data_head[v*DW +: DW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_enable = 1'b0;
    bus.rd_enable = '0;
  endtask

  task automatic wr(input int vc, input int d);
    bus.wr_enable = 1'b1;
    bus.wr_vc     = 1'(vc);
    bus.data_in   = DW'(d);
  endtask

  task automatic init_pulse();
    idle();
    init = 1'b0;
    tick();
    init = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    init  = 1'b1;
    umbral_af = {2'd1, 2'd1};
    umbral_ae = {2'd1, 2'd1};
    bus.wr_enable = 1'b0;
    bus.wr_vc     = '0;
    bus.data_in   = '0;
    bus.rd_enable = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 3);
    check("rst_full", int'(bus.full), 0);
    check("rst_valid", int'(bus.valid_out), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_ae", int'(bus.almost_empty), 3);
    check("rst_af", int'(bus.almost_full), 0);
    check("rst_head", int'(bus.data_head), 0);

    // Fill VC0 to overflow with threshold flags along the way
    for (int k = 1; k <= 5; k++) begin
      int c;
      wr(0, k);
      tick();
      c = (k > 4) ? 4 : k;
      check($sformatf("fill_count%0d", k), cnt(0), c);
      check($sformatf("fill_ae%0d", k), int'(bus.almost_empty[0]), (c <= 1) ? 1 : 0);
      check($sformatf("fill_af%0d", k), int'(bus.almost_full[0]), (c >= 3) ? 1 : 0);
      check($sformatf("fill_full%0d", k), int'(bus.full[0]), (c == 4) ? 1 : 0);
      check($sformatf("fill_err%0d", k), int'(bus.error[0]), (k == 5) ? 1 : 0);
    end
    idle();
    check("fill_head0", head(0), 1);
    check("fill_vc1_count", cnt(1), 0);
    check("fill_vc1_err", int'(bus.error[1]), 0);

    // init low clears counts and sticky error
    init_pulse();
    check("init_count0", cnt(0), 0);
    check("init_error", int'(bus.error), 0);
    check("init_head0", head(0), 0);

    // Full with simultaneous read and write
    for (int k = 1; k <= 4; k++) begin
      wr(0, k);
      tick();
    end
    check("rw_full0", int'(bus.full[0]), 1);
    wr(0, 5);
    bus.rd_enable = 2'b01;
    tick();
    check("rw_dout0", dout(0), 1);
    check("rw_valid", int'(bus.valid_out), 1);
    check("rw_count0", cnt(0), 4);
    check("rw_err0", int'(bus.error[0]), 0);
    check("rw_head0", head(0), 2);
    bus.wr_enable = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("drain_d%0d", k), dout(0), k);
      check($sformatf("drain_v%0d", k), int'(bus.valid_out), 1);
      check($sformatf("drain_c%0d", k), cnt(0), 5 - k);
    end
    idle();
    tick();
    check("drain_idle_valid", int'(bus.valid_out), 0);
    check("drain_idle_dout0", dout(0), 0);
    check("drain_empty0", int'(bus.empty[0]), 1);

    // Async reset mid-transfer
    wr(1, 6'h2A);
    tick();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 2'b10;
    tick();
    check("ar_pre_valid", int'(bus.valid_out), 2);
    check("ar_pre_dout1", dout(1), 6'h2A);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", int'(bus.valid_out), 0);
    check("ar_dout", int'(bus.data_out), 0);
    check("ar_count", int'(bus.count), 0);
    check("ar_empty", int'(bus.empty), 3);
    check("ar_error", int'(bus.error), 0);
    idle();
    #1;
    reset = 1'b0;
    tick();

    // Underflow on VC1
    bus.rd_enable = 2'b10;
    tick();
    check("uf_valid", int'(bus.valid_out), 0);
    check("uf_error", int'(bus.error), 2);
    // Read of empty VC0 with same-cycle write is not bypassed
    wr(0, 6'h11);
    bus.rd_enable = 2'b11;
    tick();
    idle();
    check("nb_valid", int'(bus.valid_out), 0);
    check("nb_error", int'(bus.error), 3);
    check("nb_count0", cnt(0), 1);
    check("nb_head0", head(0), 6'h11);
    init_pulse();
    check("nb_init_error", int'(bus.error), 0);

    // Write/read pairs on VC1 across the pointer wrap
    for (int k = 0; k < 6; k++) begin
      wr(1, 6'h20 + k);
      tick();
      bus.wr_enable = 1'b0;
      bus.rd_enable = 2'b10;
      tick();
      bus.rd_enable = '0;
      check($sformatf("wrap_d%0d", k), dout(1), 6'h20 + k);
      check($sformatf("wrap_v%0d", k), int'(bus.valid_out), 2);
    end
    check("wrap_count1", cnt(1), 0);
    check("wrap_error", int'(bus.error), 0);

    // Parallel channels, back-to-back reads
    wr(0, 6'h0A); tick();
    wr(1, 6'h1B); tick();
    wr(0, 6'h0C); tick();
    wr(1, 6'h1D); tick();
    idle();
    check("par_count0", cnt(0), 2);
    check("par_count1", cnt(1), 2);
    bus.rd_enable = 2'b11;
    tick();
    check("par_valid_a", int'(bus.valid_out), 3);
    check("par_d0_a", dout(0), 6'h0A);
    check("par_d1_a", dout(1), 6'h1B);
    tick();
    check("par_valid_b", int'(bus.valid_out), 3);
    check("par_d0_b", dout(0), 6'h0C);
    check("par_d1_b", dout(1), 6'h1D);
    tick();
    check("par_valid_c", int'(bus.valid_out), 0);
    check("par_error", int'(bus.error), 3);
    init_pulse();
    check("par_init_error", int'(bus.error), 0);
    check("par_init_empty", int'(bus.empty), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
